bin2bcd_stream: RTL and testbench

BIN2BCD_STREAM -- requirements
Module: bin2bcd_stream

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_stream.sv | 117 +++++++++++
 tb/tb_bin2bcd_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared state encoding and double-dabble constants for the streaming binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction: a digit of 5 or more gets 3 added so the following shift carries into the next decade.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + ADD3_VAL) : digit_i;
  end

endmodule

// File: rtl/bin2bcd_stream.sv
// Handshaked sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, with optional sign and saturation.
module bin2bcd_stream
  import bin2bcd_pkg::*;
#(
  parameter int W      = 18,
  parameter int D      = 6,
  parameter int SIGNED = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           binary,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*D-1:0]         bcd,
  output logic                   neg,
  output logic                   overflow,
  output logic [$clog2(D+1)-1:0] digits_used
);

  localparam int CW  = $clog2(W+1);
  localparam int DUW = $clog2(D+1);

  state_t         state_q, state_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4*D-1:0] bcd_adj;
  logic [4*D-1:0] bcd_out;
  logic           done;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_d   = (SIGNED != 0) && binary[W-1];
          mag_d   = ((SIGNED != 0) && binary[W-1]) ? (~binary + {{(W-1){1'b0}}, 1'b1}) : binary;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // Top bit of the corrected register falls off the end: the value no longer fits in D digits.
        {bcd_d, mag_d} = {bcd_adj[4*D-2:0], mag_q, 1'b0};
        ovf_d          = ovf_q | bcd_adj[4*D-1];
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = done;
  assign bcd_out   = ovf_q ? {D{4'h9}} : bcd_q;
  assign bcd       = done ? bcd_out : '0;
  assign neg       = done & neg_q;
  assign overflow  = done & ovf_q;

  // Highest nonzero digit wins; a zero result still reports one digit.
  always_comb begin
    digits_used = '0;
    if (done) begin
      digits_used = DUW'(1);
      for (int i = 0; i < D; i++) begin
        if (bcd_out[4*i +: 4] != 4'd0) begin
          digits_used = DUW'(i + 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Self-checking bench for bin2bcd_stream in a 12-bit signed, 3-digit configuration.
module tb_bin2bcd_stream;

  localparam int W   = 12;
  localparam int D   = 3;
  localparam int DUW = $clog2(D+1);

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   binary = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4*D-1:0] bcd;
  logic           neg;
  logic           overflow;
  logic [DUW-1:0] digits_used;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bin2bcd_stream #(.W(W), .D(D), .SIGNED(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .binary      (binary),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bcd         (bcd),
    .neg         (neg),
    .overflow    (overflow),
    .digits_used (digits_used)
  );

  // Reference: decimal digits of the signed value's magnitude, clamped to 999.
  function automatic void model(input logic [W-1:0] b, output logic [4*D-1:0] e_bcd,
                                output logic e_neg, output logic e_ovf, output logic [DUW-1:0] e_du);
    int v, m, s;
    v = $signed(b);
    e_neg = (v < 0);
    m = (v < 0) ? -v : v;
    e_ovf = (m > 999);
    s = e_ovf ? 999 : m;
    e_bcd = {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    e_du = (s >= 100) ? DUW'(3) : (s >= 10) ? DUW'(2) : DUW'(1);
  endfunction

  task automatic run_conv(input logic [W-1:0] b, output int lat);
    int wait_cyc;
    wait_cyc = 0;
    while (in_ready !== 1'b1 && wait_cyc < 200) begin
      @(posedge clock); #1;
      wait_cyc++;
    end
    in_valid = 1'b1;
    binary = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, bcd, neg, overflow, digits_used} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b bcd=%h neg=%b ovf=%b du=%0d want rdy=1 vld=0 bcd=000 neg=0 ovf=0 du=0",
               in_ready, out_valid, bcd, neg, overflow, digits_used);
    end
  endtask

  task automatic test_convert();
    logic [W-1:0] vals[$];
    logic [4*D-1:0] e_bcd;
    logic e_neg, e_ovf;
    logic [DUW-1:0] e_du;
    int lat;
    vals = '{12'd255, 12'd0, 12'd42, 12'd999, 12'd1000, 12'd2047, 12'hF80, 12'hFF6,
             12'h800, 12'hFFF, 12'd100, 12'd9, 12'd10, 12'hC19};
    for (int i = 0; i < 40; i++) vals.push_back(W'($urandom_range(0, 4095)));
    foreach (vals[i]) begin
      model(vals[i], e_bcd, e_neg, e_ovf, e_du);
      run_conv(vals[i], lat);
      checks++;
      if (lat != W) begin
        errors++; $display("FAIL latency in=%h: got %0d want %0d", vals[i], lat, W);
      end
      checks++;
      if ({bcd, neg, overflow, digits_used} !== {e_bcd, e_neg, e_ovf, e_du}) begin
        errors++;
        $display("FAIL result in=%h: got bcd=%h neg=%b ovf=%b du=%0d want bcd=%h neg=%b ovf=%b du=%0d",
                 vals[i], bcd, neg, overflow, digits_used, e_bcd, e_neg, e_ovf, e_du);
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat;
    run_conv(12'hFF6, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      binary = W'($urandom_range(0, 4095));
      @(posedge clock); #1;
      checks++;
      if ({out_valid, in_ready, bcd, neg, overflow, digits_used} !== {1'b1, 1'b0, 12'h010, 1'b1, 1'b0, 2'd2}) begin
        errors++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b bcd=%h neg=%b ovf=%b du=%0d want vld=1 rdy=0 bcd=010 neg=1 ovf=0 du=2",
                 i, out_valid, in_ready, bcd, neg, overflow, digits_used);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if ({out_valid, in_ready, bcd, digits_used} !== {1'b0, 1'b1, 12'h000, 2'd0}) begin
      errors++;
      $display("FAIL hold_release: got vld=%b rdy=%b bcd=%h du=%0d want vld=0 rdy=1 bcd=000 du=0",
               out_valid, in_ready, bcd, digits_used);
    end
    repeat (W + 2) @(posedge clock);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_ignored_request: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int lat;
    in_valid = 1'b1;
    binary = 12'd777;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    checks++;
    if ({out_valid, in_ready, bcd, neg, digits_used} !== {1'b0, 1'b0, 12'h000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL convert_outputs: got vld=%b rdy=%b bcd=%h neg=%b du=%0d want all 0",
               out_valid, in_ready, bcd, neg, digits_used);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, bcd} !== {1'b0, 1'b1, 12'h000}) begin
      errors++; $display("FAIL abort: got vld=%b rdy=%b bcd=%h want vld=0 rdy=1 bcd=000", out_valid, in_ready, bcd);
    end
    repeat (W + 2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_result: got vld=%b want 0", out_valid);
    end
    run_conv(12'd42, lat);
    checks++;
    if ({lat == W, bcd, digits_used} !== {1'b1, 12'h042, 2'd2}) begin
      errors++; $display("FAIL after_abort: got lat=%0d bcd=%h du=%0d want lat=%0d bcd=042 du=2", lat, bcd, digits_used, W);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [4*D-1:0] exp_q[$];
    logic [4*D-1:0] e_bcd;
    logic e_neg, e_ovf;
    logic [DUW-1:0] e_du;
    int acc_cyc[$];
    int results;
    logic took;
    results = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    binary = W'($urandom_range(0, 4095));
    for (int c = 0; c < 110; c++) begin
      took = 1'b0;
      if (in_ready === 1'b1) begin
        model(binary, e_bcd, e_neg, e_ovf, e_du);
        exp_q.push_back(e_bcd);
        acc_cyc.push_back(c);
        took = 1'b1;
      end
      if (out_valid === 1'b1) begin
        results++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result: got bcd=%h want none", bcd);
        end else begin
          e_bcd = exp_q.pop_front();
          if (bcd !== e_bcd) begin
            errors++; $display("FAIL b2b_result %0d: got bcd=%h want %h", results, bcd, e_bcd);
          end
        end
      end
      @(posedge clock); #1;
      if (took) binary = W'($urandom_range(0, 4095));
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cyc.size() < 7 || results < 6) begin
      errors++; $display("FAIL b2b_count: got accepts=%0d results=%0d want >=7 and >=6", acc_cyc.size(), results);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
        errors++; $display("FAIL b2b_spacing %0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
      end
    end
    repeat (W + 4) @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
